wb_buffer: RTL and testbench

Write-back buffer sitting directly upstream of the register file's write port. It accepts completed results (destination register number plus 64-bit value) from the execute/memory side through a valid/ready handshake and queues them in a small in-order FIFO. It drains one entry per cycle into the register file whenever the file is not busy. Two bypass lookup ports let the read stage see queued values that are not yet committed.

---
 rtl/lab2_pkg.sv | 15 +
 rtl/wb_match.sv | 36 +++
 rtl/wb_buffer.sv | 107 ++++++++++
 tb/tb_wb_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lab2_pkg.sv
// Shared types and constants for the write-back buffer and its bypass selector.
package lab2_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;

  // Register 31 reads as zero, so writes to it are never stored.
  localparam logic [DEF_ADDR_W-1:0] XZR = 5'd31;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Youngest-match selector over the occupied FIFO window (head .. head+count-1).
module wb_match
  import lab2_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  wb_entry_t                  entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [ADDR_W-1:0]          addr,
  output logic                       hit,
  output logic [DATA_W-1:0]          data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[idx].addr == addr) && (addr != XZR)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_buffer.sv
// In-order write-back FIFO feeding the register file write port, with two bypass lookups.
module wb_buffer
  import lab2_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic                     rf_busy,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [DATA_W-1:0]        byp_data1,
  output logic [DATA_W-1:0]        byp_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] match_count;
  logic             push, store, pop;

  // Handshake and write port depend only on registered state and reset.
  assign in_ready = !reset && (count_q < FULL);
  assign rf_we    = !reset && (count_q != '0);
  assign rf_waddr = rf_we ? mem_q[head_q].addr : '0;
  assign rf_wdata = rf_we ? mem_q[head_q].data : '0;
  assign count    = count_q;

  assign push  = in_valid && in_ready;
  assign store = push && (in_addr != XZR);
  assign pop   = rf_we && !rf_busy;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (store) begin
      mem_d[tail_q] = '{addr: in_addr, data: in_data};
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({store, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign match_count = reset ? '0 : count_q;

  wb_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match1 (
    .entries (mem_q),
    .head    (head_q),
    .count   (match_count),
    .addr    (rd_addr1),
    .hit     (hit1),
    .data    (byp_data1)
  );

  wb_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match2 (
    .entries (mem_q),
    .head    (head_q),
    .count   (match_count),
    .addr    (rd_addr2),
    .hit     (hit2),
    .data    (byp_data2)
  );

endmodule

// File: tb/tb_wb_buffer.sv
// Scoreboard bench for wb_buffer: accepted writes are queued, a monitor checks rf writes.
module tb_wb_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_addr = '0;
  logic [63:0] in_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        rf_busy = 1'b0;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic        hit1, hit2;
  logic [63:0] byp_data1, byp_data2;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  wb_buffer #(.DEPTH(4), .DATA_W(64), .ADDR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_busy   (rf_busy),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .hit1      (hit1),
    .hit2      (hit2),
    .byp_data1 (byp_data1),
    .byp_data2 (byp_data2),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a push for the next edge; the expected write is queued when it will be stored.
  task automatic drive_push(input logic [4:0] a, input logic [63:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    #1;
    chk("push_ready", in_ready, 1);
    if (a != 5'd31) exp_q.push_back('{addr: a, data: d});
  endtask

  // Monitor: every committed register-file write must match the oldest queued result.
  always @(negedge clk) begin
    if (rf_we === 1'b1 && rf_busy === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected none", rf_waddr, rf_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", rf_waddr, e.addr);
        chk("wr_data", rf_wdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_count", count, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_hit1", hit1, 0);
    chk("rst_byp1", byp_data1, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);

    // Single push
    drive_push(5'd3, 64'hA5);
    tick();
    in_valid = 1'b0;
    #1;
    chk("single_we", rf_we, 1);
    chk("single_waddr", rf_waddr, 3);
    chk("single_wdata", rf_wdata, 64'hA5);
    chk("single_count", count, 1);
    tick();
    chk("single_count0", count, 0);
    chk("single_we0", rf_we, 0);

    // Fill and stall
    rf_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_push(5'(i), 64'(i * 17));
      tick();
    end
    in_valid = 1'b1;
    in_addr  = 5'd9;
    in_data  = 64'h99;
    #1;
    chk("full_count", count, 4);
    chk("full_ready", in_ready, 0);
    chk("full_head", rf_waddr, 1);
    tick();
    in_valid = 1'b0;
    chk("stall_count", count, 4);
    chk("stall_head", rf_waddr, 1);
    chk("stall_data", rf_wdata, 17);
    rf_busy = 1'b0;
    tick();
    chk("drain1_count", count, 3);
    chk("drain1_ready", in_ready, 1);
    chk("drain1_head", rf_waddr, 2);
    repeat (3) tick();
    chk("drain_count0", count, 0);

    // XZR drop
    rd_addr1 = 5'd31;
    drive_push(5'd31, 64'hFF);
    tick();
    in_valid = 1'b0;
    #1;
    chk("xzr_count", count, 0);
    chk("xzr_we", rf_we, 0);
    chk("xzr_hit", hit1, 0);

    // Youngest bypass
    rf_busy = 1'b1;
    drive_push(5'd5, 64'd1);
    tick();
    rd_addr1 = 5'd5;
    drive_push(5'd5, 64'd2);
    chk("byp_first_hit", hit1, 1);
    chk("byp_first_data", byp_data1, 1);
    tick();
    in_valid = 1'b0;
    rd_addr2 = 5'd6;
    #1;
    chk("byp_young_hit", hit1, 1);
    chk("byp_young_data", byp_data1, 2);
    chk("byp_miss_hit", hit2, 0);
    chk("byp_miss_data", byp_data2, 0);
    chk("byp_count", count, 2);

    // Simultaneous push and pop, pointers wrap
    rf_busy = 1'b0;
    drive_push(5'd7, 64'h70);
    tick();
    chk("sim1_count", count, 2);
    chk("sim1_head", rf_waddr, 5);
    chk("sim1_data", rf_wdata, 2);
    drive_push(5'd8, 64'h80);
    tick();
    chk("sim2_count", count, 2);
    chk("sim2_head", rf_waddr, 7);
    drive_push(5'd9, 64'h90);
    tick();
    in_valid = 1'b0;
    rd_addr1 = 5'd9;
    #1;
    chk("sim3_count", count, 2);
    chk("sim3_head", rf_waddr, 8);
    chk("sim3_hit", hit1, 1);
    chk("sim3_byp", byp_data1, 64'h90);
    repeat (2) tick();
    chk("sim_count0", count, 0);

    // Reset mid-stream
    rf_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_push(5'(10 + i), 64'h100 + 64'(i));
      tick();
    end
    in_valid = 1'b0;
    rd_addr1 = 5'd10;
    #1;
    chk("mid_count3", count, 3);
    chk("mid_hit_pre", hit1, 1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_we", rf_we, 0);
    tick();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_waddr", rf_waddr, 0);
    chk("mid_rst_wdata", rf_wdata, 0);
    chk("mid_rst_hit", hit1, 0);
    reset = 1'b0;
    rf_busy = 1'b0;
    #1;
    chk("mid_rel_ready", in_ready, 1);
    chk("mid_rel_we", rf_we, 0);
    repeat (2) tick();
    chk("mid_rel_count", count, 0);

    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
